// File: rtl/square_seq_if.sv
// Result stream for square_seq: one (x, x^2) pair per valid/ready handshake.
// The producer drives valid and data; the consumer drives ready.
interface square_seq_if #(
    parameter int W = 4
);
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   x_out;
    logic [2*W-1:0] sq_out;

    modport master (
        output out_valid,
        output x_out,
        output sq_out,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  x_out,
        input  sq_out,
        output out_ready
    );
endinterface

// File: rtl/square_seq.sv
// Streams x^2 for x = x_first .. x_last (wrapping), built incrementally
// with (x+1)^2 = x^2 + 2x + 1 so no multiplier is needed.
module square_seq #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x_first,
    input  logic [W-1:0] x_last,
    output logic         busy,
    output logic         done,
    square_seq_if.master res
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [W-1:0]   x;
    logic [2*W-1:0] sq;
    logic [W-1:0]   lo;
    logic [W-1:0]   hi;
    logic [2*W-1:0] sq_step;
    logic           at_lo;
    logic           at_hi;
    logic           hs;

    // The odd term 2x+1 is just x shifted left with a 1 in the LSB.
    assign sq_step = sq + {{(W-1){1'b0}}, x, 1'b1};
    assign at_lo   = (x == lo);
    assign at_hi   = (x == hi);
    assign hs      = (state == RUN) && res.out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: seed walks up from zero, run emits until x_last.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = SEED;
            SEED: if (at_lo) state_nx = RUN;
            RUN:  if (hs && at_hi) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from the registered state and datapath.
    always_comb begin
        res.out_valid = (state == RUN);
        res.x_out     = x;
        res.sq_out    = sq;
        busy          = (state != IDLE);
        done          = (state == DONE);
    end

    // Datapath: bound latching and the incremental square recurrence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x  <= '0;
            sq <= '0;
            lo <= '0;
            hi <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        lo <= x_first;
                        hi <= x_last;
                        x  <= '0;
                        sq <= '0;
                    end
                end
                SEED: begin
                    if (!at_lo) begin
                        x  <= x + 1'b1;
                        sq <= sq_step;
                    end
                end
                RUN: begin
                    if (hs && !at_hi) begin
                        x  <= x + 1'b1;
                        sq <= sq_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
